// File: rtl/jr_fwd_pkg.sv
// Shared constants and types for the jr/jalr target forwarding controller.
package jr_fwd_pkg;

    localparam logic [3:0] SEL_RF     = 4'b0001;
    localparam logic [3:0] SEL_ALU    = 4'b0010;
    localparam logic [3:0] SEL_EXEMEM = 4'b0100;
    localparam logic [3:0] SEL_MEMWB  = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/jr_hit_cmp.sv
// Single-stage producer match: a stage hits when it writes the jump's rs (r0 never hits).
module jr_hit_cmp (
    input  logic       wr_en,
    input  logic [4:0] wr_reg,
    input  logic [4:0] rs,
    output logic       hit
);

    assign hit = wr_en && (wr_reg == rs) && (rs != 5'd0);

endmodule

// File: rtl/jr_fwd_ctrl.sv
// Jump-register target forwarding and load-use stall control for the ID stage.
//   state | meaning
//   IDLE  | resolve jr target from regfile/ALU/EXE-MEM/MEM-WB, or start a load stall
//   WAIT  | ID frozen behind a load; cnt=1 -> one more stall, cnt=0 -> take MEM/WB value
module jr_fwd_ctrl
    import jr_fwd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_is_jr,
    input  logic [4:0]  id_rs,
    input  logic        exe_wr_en,
    input  logic [4:0]  exe_wr_reg,
    input  logic        exe_is_load,
    input  logic        mem_wr_en,
    input  logic [4:0]  mem_wr_reg,
    input  logic        mem_is_load,
    input  logic        wb_wr_en,
    input  logic [4:0]  wb_wr_reg,
    input  logic        flush,
    output logic [3:0]  sel,
    output logic        stall,
    output logic [15:0] stall_cycles
);

    state_e     state, state_nxt;
    logic       cnt, cnt_nxt;
    logic [4:0] rs_q, rs_nxt;
    logic       exe_hit, mem_hit, wb_hit;

    jr_hit_cmp u_exe_cmp (.wr_en(exe_wr_en), .wr_reg(exe_wr_reg), .rs(id_rs), .hit(exe_hit));
    jr_hit_cmp u_mem_cmp (.wr_en(mem_wr_en), .wr_reg(mem_wr_reg), .rs(id_rs), .hit(mem_hit));
    jr_hit_cmp u_wb_cmp  (.wr_en(wb_wr_en),  .wr_reg(wb_wr_reg),  .rs(id_rs), .hit(wb_hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 1'b0;
            rs_q         <= 5'd0;
            stall_cycles <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rs_q  <= rs_nxt;
            if (stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rs_nxt    = rs_q;
        sel       = SEL_RF;
        stall     = 1'b0;
        // Reset is checked here too so outputs stay quiet while rst_n is held low.
        if (!rst_n) begin
            state_nxt = IDLE;
            cnt_nxt   = 1'b0;
        end else if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (id_valid && id_is_jr) begin
                        if (exe_hit) begin
                            if (exe_is_load) begin
                                stall     = 1'b1;
                                state_nxt = WAIT;
                                cnt_nxt   = 1'b1;
                                rs_nxt    = id_rs;
                            end else begin
                                sel = SEL_ALU;
                            end
                        end else if (mem_hit) begin
                            if (mem_is_load) begin
                                stall     = 1'b1;
                                state_nxt = WAIT;
                                cnt_nxt   = 1'b0;
                                rs_nxt    = id_rs;
                            end else begin
                                sel = SEL_EXEMEM;
                            end
                        end else if (wb_hit) begin
                            sel = SEL_MEMWB;
                        end
                    end
                end
                WAIT: begin
                    if (cnt) begin
                        stall   = 1'b1;
                        cnt_nxt = 1'b0;
                    end else begin
                        sel       = SEL_MEMWB;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 1'b0;
                end
            endcase
        end
    end

    // ID must hold the same jump while the load result is in flight.
    a_id_frozen: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WAIT) |-> (id_is_jr && (id_rs == rs_q)))
        else $error("jr_fwd_ctrl: ID changed while in WAIT");

endmodule

// File: tb/tb_jr_fwd_ctrl.sv
// Directed self-checking bench for jr_fwd_ctrl.
module tb_jr_fwd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid, id_is_jr;
    logic [4:0]  id_rs;
    logic        exe_wr_en, exe_is_load;
    logic [4:0]  exe_wr_reg;
    logic        mem_wr_en, mem_is_load;
    logic [4:0]  mem_wr_reg;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_reg;
    logic        flush;
    logic [3:0]  sel;
    logic        stall;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_cycles;

    jr_fwd_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_is_jr(id_is_jr), .id_rs(id_rs),
        .exe_wr_en(exe_wr_en), .exe_wr_reg(exe_wr_reg), .exe_is_load(exe_is_load),
        .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_is_load(mem_is_load),
        .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg),
        .flush(flush),
        .sel(sel), .stall(stall), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic jr, input logic [4:0] rs,
                         input logic ewe, input logic [4:0] ereg, input logic eld,
                         input logic mwe, input logic [4:0] mreg, input logic mld,
                         input logic wwe, input logic [4:0] wreg);
        id_valid = v;   id_is_jr = jr;    id_rs = rs;
        exe_wr_en = ewe; exe_wr_reg = ereg; exe_is_load = eld;
        mem_wr_en = mwe; mem_wr_reg = mreg; mem_is_load = mld;
        wb_wr_en = wwe;  wb_wr_reg = wreg;
    endtask

    // Advance to the next cycle's low phase; inputs change here and outputs settle by #1.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        drive(1, 1, 5'd4, 1, 5'd4, 1, 0, 5'd0, 0, 0, 5'd0);
        cyc(); cyc(); #1;
        checks++; if (sel !== 4'b0001) begin failures++; $display("FAIL reset_sel got=%b exp=0001", sel); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_cycles got=%h exp=0000", stall_cycles); end
        cyc();
        drive(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        rst_n = 1'b1;
        exp_cycles = 16'd0;
    endtask

    task automatic test_priority();
        cyc(); drive(1, 1, 5'd5, 1, 5'd5, 0, 1, 5'd5, 0, 1, 5'd5); #1;
        checks++; if (sel !== 4'b0010) begin failures++; $display("FAIL prio_exe_sel got=%b exp=0010", sel); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL prio_exe_stall got=%b exp=0", stall); end
        cyc(); drive(1, 1, 5'd5, 1, 5'd5, 0, 1, 5'd5, 1, 0, 5'd0); #1;
        checks++; if (sel !== 4'b0010 || stall !== 1'b0) begin failures++; $display("FAIL prio_exe_over_memload got sel=%b stall=%b exp sel=0010 stall=0", sel, stall); end
        cyc(); drive(1, 1, 5'd5, 1, 5'd6, 0, 1, 5'd5, 0, 1, 5'd5); #1;
        checks++; if (sel !== 4'b0100) begin failures++; $display("FAIL prio_mem_sel got=%b exp=0100", sel); end
        cyc(); drive(1, 1, 5'd7, 0, 5'd7, 0, 1, 5'd6, 0, 1, 5'd7); #1;
        checks++; if (sel !== 4'b1000) begin failures++; $display("FAIL wb_sel got=%b exp=1000", sel); end
        cyc(); drive(1, 1, 5'd7, 1, 5'd1, 0, 1, 5'd2, 1, 1, 5'd3); #1;
        checks++; if (sel !== 4'b0001 || stall !== 1'b0) begin failures++; $display("FAIL nohit got sel=%b stall=%b exp sel=0001 stall=0", sel, stall); end
        cyc(); drive(1, 0, 5'd5, 1, 5'd5, 1, 0, 5'd0, 0, 0, 5'd0); #1;
        checks++; if (sel !== 4'b0001 || stall !== 1'b0) begin failures++; $display("FAIL not_jr got sel=%b stall=%b exp sel=0001 stall=0", sel, stall); end
        cyc(); drive(0, 1, 5'd5, 1, 5'd5, 1, 0, 5'd0, 0, 0, 5'd0); #1;
        checks++; if (sel !== 4'b0001 || stall !== 1'b0) begin failures++; $display("FAIL not_valid got sel=%b stall=%b exp sel=0001 stall=0", sel, stall); end
    endtask

    task automatic test_rs_zero();
        cyc(); drive(1, 1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 1, 1, 5'd0); #1;
        checks++; if (sel !== 4'b0001 || stall !== 1'b0) begin failures++; $display("FAIL rs_zero got sel=%b stall=%b exp sel=0001 stall=0", sel, stall); end
        cyc(); drive(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0); #1;
        checks++; if (stall_cycles !== exp_cycles) begin failures++; $display("FAIL cycles_no_stall got=%h exp=%h", stall_cycles, exp_cycles); end
    endtask

    task automatic test_exe_load();
        cyc(); drive(1, 1, 5'd8, 1, 5'd8, 1, 0, 5'd0, 0, 0, 5'd0); #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL exe_load_c1_stall got=%b exp=1", stall); end
        cyc(); drive(1, 1, 5'd8, 0, 5'd0, 0, 1, 5'd8, 1, 0, 5'd0); #1;
        checks++; if (stall !== 1'b1 || sel !== 4'b0001) begin failures++; $display("FAIL exe_load_c2 got stall=%b sel=%b exp stall=1 sel=0001", stall, sel); end
        cyc(); drive(1, 1, 5'd8, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd8); #1;
        checks++; if (stall !== 1'b0 || sel !== 4'b1000) begin failures++; $display("FAIL exe_load_c3 got stall=%b sel=%b exp stall=0 sel=1000", stall, sel); end
        exp_cycles = 16'd2;
        checks++; if (stall_cycles !== exp_cycles) begin failures++; $display("FAIL exe_load_cycles got=%h exp=%h", stall_cycles, exp_cycles); end
    endtask

    task automatic test_mem_load();
        cyc(); drive(1, 1, 5'd9, 1, 5'd3, 0, 1, 5'd9, 1, 0, 5'd0); #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mem_load_c1_stall got=%b exp=1", stall); end
        cyc(); drive(1, 1, 5'd9, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd9); #1;
        checks++; if (stall !== 1'b0 || sel !== 4'b1000) begin failures++; $display("FAIL mem_load_c2 got stall=%b sel=%b exp stall=0 sel=1000", stall, sel); end
        cyc(); drive(1, 1, 5'd9, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0); #1;
        checks++; if (stall !== 1'b0 || sel !== 4'b0001) begin failures++; $display("FAIL mem_load_idle got stall=%b sel=%b exp stall=0 sel=0001", stall, sel); end
        exp_cycles = 16'd3;
        checks++; if (stall_cycles !== exp_cycles) begin failures++; $display("FAIL mem_load_cycles got=%h exp=%h", stall_cycles, exp_cycles); end
    endtask

    task automatic test_flush();
        cyc(); drive(1, 1, 5'd8, 1, 5'd8, 1, 0, 5'd0, 0, 0, 5'd0); #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_c1_stall got=%b exp=1", stall); end
        cyc(); flush = 1'b1; #1;
        checks++; if (stall !== 1'b0 || sel !== 4'b0001) begin failures++; $display("FAIL flush_c2 got stall=%b sel=%b exp stall=0 sel=0001", stall, sel); end
        cyc(); flush = 1'b0; drive(1, 1, 5'd11, 1, 5'd11, 0, 0, 5'd0, 0, 0, 5'd0); #1;
        checks++; if (stall !== 1'b0 || sel !== 4'b0010) begin failures++; $display("FAIL flush_idle got stall=%b sel=%b exp stall=0 sel=0010", stall, sel); end
        exp_cycles = 16'd4;
        checks++; if (stall_cycles !== exp_cycles) begin failures++; $display("FAIL flush_cycles got=%h exp=%h", stall_cycles, exp_cycles); end
    endtask

    task automatic test_reset_mid_wait();
        cyc(); drive(1, 1, 5'd8, 1, 5'd8, 1, 0, 5'd0, 0, 0, 5'd0); #1;
        cyc(); rst_n = 1'b0; #1;
        checks++; if (stall !== 1'b0 || sel !== 4'b0001) begin failures++; $display("FAIL rst_mid got stall=%b sel=%b exp stall=0 sel=0001", stall, sel); end
        exp_cycles = 16'd0;
        checks++; if (stall_cycles !== exp_cycles) begin failures++; $display("FAIL rst_mid_cycles got=%h exp=%h", stall_cycles, exp_cycles); end
        cyc(); rst_n = 1'b1; drive(1, 1, 5'd8, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0); #1;
        cyc(); #1;
        checks++; if (stall !== 1'b0 || sel !== 4'b0001) begin failures++; $display("FAIL rst_release got stall=%b sel=%b exp stall=0 sel=0001", stall, sel); end
        checks++; if (stall_cycles !== exp_cycles) begin failures++; $display("FAIL rst_release_cycles got=%h exp=%h", stall_cycles, exp_cycles); end
    endtask

    task automatic test_saturation();
        cyc(); drive(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        force dut.stall_cycles = 16'hFFFE;
        #1;
        release dut.stall_cycles;
        #1;
        checks++; if (stall_cycles !== 16'hFFFE) begin failures++; $display("FAIL sat_preload got=%h exp=fffe", stall_cycles); end
        cyc(); drive(1, 1, 5'd12, 1, 5'd12, 1, 0, 5'd0, 0, 0, 5'd0); #1;
        cyc(); #1;
        cyc(); #1;
        checks++; if (stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL sat_two got=%h exp=ffff", stall_cycles); end
        cyc(); drive(1, 1, 5'd13, 0, 5'd0, 0, 1, 5'd13, 1, 0, 5'd0); #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_third_stall got=%b exp=1", stall); end
        cyc(); #1;
        cyc(); drive(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0); #1;
        checks++; if (stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_rs_zero();
        test_exe_load();
        test_mem_load();
        test_flush();
        test_reset_mid_wait();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
